axi4lite_master_bridge: RTL and testbench
=========================================

// Module: axi4lite_master_bridge
// PURPOSE
//  Initiator end of the AXI4-Lite register interface: converts single requests from a simple
//  local request/response port into AXI4-Lite read or write transactions toward a generated
//  register-bank responder. One outstanding transaction at a time. Sits in the controlling
//  logic (sequencer, CPU shim) in front of the register map.
// PARAMETERS
//  ADDR_WIDTH  32      byte address width of awaddr/araddr/req_addr
//  DATA_WIDTH  32      data width; 32 or 64; strobe width = DATA_WIDTH/8
//  PROT        3'b000  constant driven on awprot/arprot
// PORTS
//  aclk        in   1             clock, all logic rising-edge
//  areset      in   1             asynchronous, active-high reset
//  req_valid   in   1             local request present
//  req_ready   out  1             request accepted when req_valid & req_ready
//  req_write   in   1             1 = write, 0 = read
//  req_addr    in   ADDR_WIDTH    byte address
//  req_wdata   in   DATA_WIDTH    write data
//  req_wstrb   in   DATA_WIDTH/8  write byte strobes
//  rsp_valid   out  1             one-cycle response pulse
//  rsp_rdata   out  DATA_WIDTH    read data (0 on writes)
//  rsp_err     out  1             1 = SLVERR/DECERR returned
//  busy        out  1             transaction in flight (state != IDLE)
//  awvalid/awready/awaddr/awprot, wvalid/wready/wdata/wstrb, bvalid/bready/bresp,
//  arvalid/arready/araddr/arprot, rvalid/rready/rdata/rresp: standard AXI4-Lite initiator
//  directions; bresp/rresp 2 bits, awprot/arprot 3 bits
// BEHAVIOUR
//  Reset (async assert, released synchronously by the system): state IDLE; all AXI valid/ready
//   outputs 0; awaddr/araddr/wdata/wstrb/rsp_rdata 0; rsp_valid 0; rsp_err 0; busy 0.
//   Reset mid-transaction abandons it with no response; the responder shares the same reset.
//  All AXI outputs are registered; no combinational path from any input to any AXI output.
//  req_ready = (state == IDLE) and not in reset.
//  FSM: IDLE, WR, WRESP, RD_A, RD_D.
//   IDLE: on req_valid, latch addr/data/strb.
//    - Write: go to WR; set awvalid=1 and wvalid=1 (visible the next cycle).
//    - Read: go to RD_A; set arvalid=1.
//   WR: AW and W complete independently in either order or in the same cycle.
//    - awvalid drops the cycle after awready is sampled high with awvalid; wvalid likewise.
//    - Once both have handshaken (including both in one cycle), go to WRESP with bready=1.
//    - bvalid is ignored in WR (bready=0).
//   WRESP: on bvalid & bready: bready<=0; rsp_valid<=1; rsp_err<=bresp[1]; rsp_rdata<=0; go IDLE.
//   RD_A: on arready & arvalid: arvalid<=0, rready<=1, go to RD_D.
//   RD_D: on rvalid & rready: rready<=0; rsp_rdata<=rdata; rsp_err<=rresp[1]; rsp_valid<=1;
//    go IDLE.
//  AXI stability: address, data and strobe are held constant while the matching valid is high.
//   A valid, once raised, never drops before its handshake.
//  rsp_valid is high exactly one cycle, the cycle after the B/R handshake; no backpressure.
//   rsp_rdata/rsp_err hold their value until the next response.
//   A new request can be accepted in the same cycle rsp_valid is high.
//  Latency with a zero-wait responder (which asserts ready while valid is high, and
//   bvalid/rvalid on the next cycle):
//   - Write: request accepted at cycle 0, rsp_valid at cycle 4.
//   - Read: request accepted at cycle 0, rsp_valid at cycle 4.
//  bresp/rresp OKAY(00) and EXOKAY(01) -> rsp_err 0; SLVERR(10) and DECERR(11) -> rsp_err 1.
// TESTING
//  1 Write, zero-wait responder, addr 0x4, data 0xDEADBEEF, strb 0xF -> exactly one AW+W beat
//    with those values, awprot=PROT, rsp_valid at cycle 4, rsp_err 0.
//  2 Write, awready delayed 3 cycles, wready immediate (then reversed) -> awaddr/wdata stable
//    while valid, one B handshake, exactly one rsp_valid pulse.
//  3 Read addr 0x0, responder returns rdata 0x12345678 with rvalid delayed 5 cycles ->
//    rsp_rdata 0x12345678, rsp_err 0; req_ready 0 throughout.
//  4 Read returning rresp=2'b10 -> rsp_err 1; next write returning bresp=2'b00 -> rsp_err 0,
//    rsp_rdata 0.
//  5 Back-to-back: req_valid held high with write then read -> second request accepted in the
//    rsp_valid cycle of the first; no overlap of AW/AR.
//  6 areset asserted while awvalid=1 in WR -> all AXI valids 0 immediately (async),
//    busy 0, no rsp_valid; after release a fresh read completes normally.

Source files
------------

// File: rtl/axi4lite_master_bridge.sv
// AXI4-Lite initiator: turns single local read/write requests into AXI4-Lite
// transactions, one outstanding at a time, with every AXI output registered.
module axi4lite_master_bridge #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                    aclk,
  input  logic                    areset,
  // local request/response port
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  // AXI4-Lite write address / data / response
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  // AXI4-Lite read address / data
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD_A, RD_D} state_t;

  state_t                  state, state_d;
  logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_d, rsp_rdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_d;
  logic                    rsp_valid_d, rsp_err_d;
  logic                    aw_done, w_done;

  assign awprot    = PROT;
  assign arprot    = PROT;
  assign req_ready = (state == IDLE) && !areset;
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    bready_d    = bready;
    arvalid_d   = arvalid;
    rready_d    = rready;
    awaddr_d    = awaddr;
    araddr_d    = araddr;
    wdata_d     = wdata;
    wstrb_d     = wstrb;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    rsp_valid_d = 1'b0;
    aw_done     = 1'b0;
    w_done      = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end

      WR: begin
        // A channel whose valid is already low has completed its handshake earlier.
        aw_done = !awvalid || awready;
        w_done  = !wvalid  || wready;
        if (awvalid && awready) awvalid_d = 1'b0;
        if (wvalid && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end

      WRESP: begin
        if (bvalid && bready) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bresp[1];
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end

      RD_A: begin
        if (arvalid && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end

      RD_D: begin
        if (rvalid && rready) begin
          rready_d    = 1'b0;
          rsp_rdata_d = rdata;
          rsp_err_d   = rresp[1];
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      bready    <= bready_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      awaddr    <= awaddr_d;
      araddr    <= araddr_d;
      wdata     <= wdata_d;
      wstrb     <= wstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Bench for axi4lite_master_bridge: random requests against a behavioural register-bank model,
// a configurable-latency AXI4-Lite responder, and a scoreboard monitor that checks every response.
module tb_axi4lite_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          aclk, areset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axi4lite_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  typedef struct {
    int aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0] resp;
  } cfg_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [DW-1:0] rdata;
    bit            err;
    int            acc;
    bit            zw;
  } exp_t;

  cfg_t cfg_q[$];
  exp_t exp_q[$];
  logic [DW-1:0] model_mem[int];
  logic [DW-1:0] resp_mem[int];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Register bank contents for a word never written: a fixed function of its address.
  function automatic logic [DW-1:0] blank_word(input logic [AW-1:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_C0DE;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < SW; i++)
      if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    int k;
    k = int'(a >> 2);
    return model_mem.exists(k) ? model_mem[k] : blank_word(a & ~32'h3);
  endfunction

  function automatic logic [DW-1:0] resp_read(input logic [AW-1:0] a);
    int k;
    k = int'(a >> 2);
    return resp_mem.exists(k) ? resp_mem[k] : blank_word(a & ~32'h3);
  endfunction

  // ---------------- responder: decides at negedge, drives just after posedge ----------------
  initial begin : responder
    bit            active, aw_got, w_got, ar_got;
    int            aw_c, w_c, b_c, ar_c, r_c;
    cfg_t          cur;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;
    logic          n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
    logic [1:0]    n_bresp, n_rresp;
    logic [DW-1:0] n_rdata;
    active = 0; aw_got = 0; w_got = 0; ar_got = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge aclk);
      n_awready = awready; n_wready = wready; n_bvalid = bvalid; n_bresp = bresp;
      n_arready = arready; n_rvalid = rvalid; n_rdata = rdata; n_rresp = rresp;
      if (areset) begin
        active = 0; aw_got = 0; w_got = 0; ar_got = 0;
        n_awready = 0; n_wready = 0; n_bvalid = 0; n_arready = 0; n_rvalid = 0;
      end else begin
        if (!active && (awvalid || wvalid || arvalid)) begin
          if (cfg_q.size() == 0) check("responder_unexpected_txn", 1, 0);
          else begin
            cur = cfg_q.pop_front();
            active = 1; aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
          end
        end
        if (active) begin
          if (awvalid && awready) begin
            aw_got = 1; cap_awaddr = awaddr; n_awready = 0;
          end else if (awvalid && !aw_got) begin
            if (aw_c >= cur.aw_d) n_awready = 1; else aw_c++;
          end
          if (wvalid && wready) begin
            w_got = 1; cap_wdata = wdata; cap_wstrb = wstrb; n_wready = 0;
          end else if (wvalid && !w_got) begin
            if (w_c >= cur.w_d) n_wready = 1; else w_c++;
          end
          if (arvalid && arready) begin
            ar_got = 1; cap_araddr = araddr; n_arready = 0;
          end else if (arvalid && !ar_got) begin
            if (ar_c >= cur.ar_d) n_arready = 1; else ar_c++;
          end
          if (bvalid && bready) begin
            n_bvalid = 0; active = 0; aw_got = 0; w_got = 0;
          end else if (aw_got && w_got && !bvalid) begin
            if (b_c >= cur.b_d) begin
              n_bvalid = 1; n_bresp = cur.resp;
              if (!cur.resp[1])
                resp_mem[int'(cap_awaddr >> 2)] = merge(resp_read(cap_awaddr), cap_wdata, cap_wstrb);
            end else b_c++;
          end
          if (rvalid && rready) begin
            n_rvalid = 0; active = 0; ar_got = 0;
          end else if (ar_got && !rvalid) begin
            if (r_c >= cur.r_d) begin
              n_rvalid = 1; n_rresp = cur.resp; n_rdata = resp_read(cap_araddr);
            end else r_c++;
          end
        end
      end
      @(posedge aclk);
      #1;
      awready = n_awready; wready = n_wready; bvalid = n_bvalid; bresp = n_bresp;
      arready = n_arready; rvalid = n_rvalid; rdata = n_rdata; rresp = n_rresp;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int aw_n, w_n, ar_n;
    logic p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [SW-1:0] p_wstrb;
    bit   exp_busy;
    exp_t e;
    aw_n = 0; w_n = 0; ar_n = 0;
    p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_arvalid = 0; p_arready = 0;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        aw_n = 0; w_n = 0; ar_n = 0;
      end else begin
        if (p_awvalid && !p_awready) begin
          check("awvalid_held", awvalid, 1);
          check("awaddr_stable", awaddr, p_awaddr);
        end
        if (p_wvalid && !p_wready) begin
          check("wvalid_held", wvalid, 1);
          check("wdata_stable", wdata, p_wdata);
          check("wstrb_stable", wstrb, p_wstrb);
        end
        if (p_arvalid && !p_arready) begin
          check("arvalid_held", arvalid, 1);
          check("araddr_stable", araddr, p_araddr);
        end
        if (awvalid || wvalid || arvalid)
          check("no_aw_ar_overlap", arvalid && (awvalid || wvalid), 0);

        if (awvalid && awready) begin
          aw_n++;
          if (exp_q.size() == 0) check("aw_unexpected", 1, 0);
          else begin
            check("awaddr", awaddr, exp_q[0].addr);
            check("awprot", awprot, 3'b000);
          end
        end
        if (wvalid && wready) begin
          w_n++;
          if (exp_q.size() == 0) check("w_unexpected", 1, 0);
          else begin
            check("wdata", wdata, exp_q[0].wdata);
            check("wstrb", wstrb, exp_q[0].strb);
          end
        end
        if (arvalid && arready) begin
          ar_n++;
          if (exp_q.size() == 0) check("ar_unexpected", 1, 0);
          else begin
            check("araddr", araddr, exp_q[0].addr);
            check("arprot", arprot, 3'b000);
          end
        end

        exp_busy = (exp_q.size() > 0) && (exp_q[0].acc >= 0) && (exp_q[0].acc < cyc) && !rsp_valid;
        check("busy", busy, exp_busy);
        check("req_ready", req_ready, !exp_busy);

        if (rsp_valid) begin
          if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check(e.wr ? "wr_rsp_rdata" : "rd_rsp_rdata", rsp_rdata, e.rdata);
            check(e.wr ? "wr_rsp_err" : "rd_rsp_err", rsp_err, e.err);
            check("aw_beats", aw_n, e.wr ? 1 : 0);
            check("w_beats", w_n, e.wr ? 1 : 0);
            check("ar_beats", ar_n, e.wr ? 0 : 1);
            if (e.zw) check("zero_wait_latency", cyc - e.acc, 4);
          end
          aw_n = 0; w_n = 0; ar_n = 0;
        end
      end
      p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
      p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wstrb = wstrb;
      p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; returns just after the rising edge that accepted the request.
  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] strb, input int aw_d, input int w_d, input int b_d,
                       input int ar_d, input int r_d, input logic [1:0] resp,
                       input bit keep, input bit follow);
    cfg_t c;
    exp_t e;
    bit   ok;
    c = '{aw_d: aw_d, w_d: w_d, b_d: b_d, ar_d: ar_d, r_d: r_d, resp: resp};
    e.wr = wr; e.addr = addr; e.wdata = data; e.strb = strb; e.err = resp[1]; e.acc = -1;
    if (wr) begin
      e.rdata = '0;
      e.zw    = (aw_d == 0) && (w_d == 0) && (b_d == 0);
      if (!resp[1]) model_mem[int'(addr >> 2)] = merge(model_read(addr), data, strb);
    end else begin
      e.rdata = model_read(addr);
      e.zw    = (ar_d == 0) && (r_d == 0);
    end
    cfg_q.push_back(c);
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge aclk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      check("req_accept_timeout", 1, 0);
      exp_q.delete();
      cfg_q.delete();
    end else begin
      exp_q[exp_q.size()-1].acc = cyc;
      if (follow) check("b2b_accept_in_rsp_cycle", rsp_valid, 1);
    end
    @(posedge aclk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      check("response_timeout", 1, 0);
      exp_q.delete();
      cfg_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin : stimulus
    bit         wr, keep, follow;
    logic [1:0] resp;
    areset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    repeat (3) @(negedge aclk);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready_rready", {bready, rready}, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy_rsp", {busy, rsp_valid, rsp_err}, 0);
    check("rst_addr_data", {awaddr, araddr, wdata, wstrb}, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("req_ready_after_reset", req_ready, 1);
    @(posedge aclk);
    #1;

    // single zero-wait write
    issue(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    wait_idle();
    // AW late then W late
    issue(1, 32'h8, 32'hCAFE0001, 4'hF, 3, 0, 0, 0, 0, 2'b00, 0, 0);
    wait_idle();
    issue(1, 32'hC, 32'hCAFE0002, 4'h5, 0, 3, 1, 0, 0, 2'b01, 0, 0);
    wait_idle();
    // slow read of a known word
    issue(1, 32'h0, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    wait_idle();
    issue(0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 0, 0);
    wait_idle();
    // error read, then clean write clears rsp_err and rsp_rdata
    issue(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 0, 0);
    wait_idle();
    issue(1, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    wait_idle();
    // back-to-back write then read with req_valid held
    issue(1, 32'h14, 32'h01020304, 4'hF, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    issue(0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    wait_idle();

    // reset while a write sits in WR with awvalid high
    cfg_q.push_back('{aw_d: 40, w_d: 40, b_d: 0, ar_d: 0, r_d: 0, resp: 2'b00});
    exp_q.push_back('{wr: 1, addr: 32'h0, wdata: 32'hBAD0BAD0, strb: 4'hF, rdata: 32'h0,
                      err: 0, acc: -1, zw: 0});
    req_valid = 1; req_write = 1; req_addr = 32'h0; req_wdata = 32'hBAD0BAD0; req_wstrb = 4'hF;
    @(negedge aclk);
    exp_q[0].acc = cyc;
    @(posedge aclk);
    #1 req_valid = 0;
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    check("arst_awvalid", awvalid, 0);
    check("arst_wvalid", wvalid, 0);
    check("arst_arvalid_bready_rready", {arvalid, bready, rready}, 0);
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    cfg_q.delete();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    issue(0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    wait_idle();

    // randomized traffic
    follow = 0;
    for (int n = 0; n < 120; n++) begin
      wr   = $urandom_range(0, 1);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      keep = (n < 119) && ($urandom_range(0, 1) == 1);
      issue(wr, 32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom_range(0, 3), resp, keep, follow);
      follow = keep;
      if (!keep) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) @(posedge aclk);
        #1;
      end
    end
    wait_idle();
    repeat (5) @(posedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
